monitor_cmd_ctrl: RTL and testbench
===================================

# monitor_cmd_ctrl

Parametrised UART-monitor command controller for the next board revision. It consumes received ASCII characters from the UART receiver and parses one-letter commands (g, w, r, t, s, q) followed by variable-length hexadecimal tokens. Address and data fields have configurable widths. It drives the same memory-write, dump, trash, step and CPU-start strobes to the monitor datapath, and adds uppercase hex, separator-terminated tokens, per-field overflow checking and an error strobe.

## Interface
- `ADR_W`, 8, address field width in bits; multiple of 4, 4..32.
- `DAT_W`, 8, data field width in bits; multiple of 4, 4..32.
- `ACC_W`, max(ADR_W, DAT_W), derived, accumulator width.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rout` in 8: received character.
- `rout_en` in 1: one-cycle strobe; `rout` is valid.
- `dump_running`, `trush_running`, `cpu_running` in 1 each: busy flags from the dump, trash and CPU blocks.
- `adr_out` out ADR_W: last completed address token.
- `dat_out` out DAT_W: last completed data token.
- `cpu_start`, `write_address_set`, `write_data_en`, `read_start_set`, `read_end_set`, `read_stop`, `start_trush`, `start_step`, `quit_cmd` out 1 each: one-cycle pulses.
- `crlf_in` out 1: one-cycle pulse requesting CR/LF echo.
- `cmd_err` out 1: one-cycle pulse on a parse error.

## Operation
- **Character classes:**
  - Hex digits: `0-9`, `a-f`, `A-F`.
  - Separator: space 0x20 or CR 0x0d.
  - Commands: `g`, `w`, `r`, `t`, `s`, `q`.
  - Every other character is "other".
- **Token accumulation:**
  - A hex digit shifts `acc` left 4 and inserts the nibble, then increments `ndig`.
  - A separator with `ndig>0` completes the token: the value is `acc` zero-extended into the field, after which `acc` and `ndig` clear.
  - A separator with `ndig==0` is ignored, so runs of separators are allowed.
- **Field limit:** the current field allows ADR_W/4 digits for address fields and DAT_W/4 for data fields. One more digit fires `cmd_err`, clears the token and sends the state to IDLE.
- **State machine:**
  - IDLE:
    - `g` → G_ADR.
    - `w` → W_ADR.
    - `r` → R_STA.
    - `t` → T_RUN.
    - `s` → S_RUN.
    - Digits, separators and other characters are ignored.
  - G_ADR: token → G_RUN, loading `adr_out` and pulsing `cpu_start`.
  - G_RUN: stays until `q`.
  - W_ADR: token → W_DAT, loading `adr_out` and pulsing `write_address_set`.
  - W_DAT: each token loads `dat_out` and pulses `write_data_en`; remains in W_DAT.
  - R_STA: token → R_END, loading `adr_out` and pulsing `read_start_set`.
  - R_END: token → R_DUMP, loading `adr_out` and pulsing `read_end_set`.
  - R_DUMP: → IDLE on `q` (pulses `read_stop`) or on `~dump_running`.
  - T_RUN: → IDLE on `q` or `~trush_running`.
  - S_RUN: → IDLE on `q` or `~cpu_running`.
  - Entering T_RUN pulses `start_trush`; entering S_RUN pulses `start_step`.
- **`q` in any state:** → IDLE, pulses `quit_cmd`, discards any partial token and issues no write.
- **Errors in a token-collecting state:** a command letter other than `q`, or an "other" character, fires `cmd_err`, clears the token and sends the state to IDLE.
- **`crlf_in` pulses on:**
  - any `q`, `t` or `s` in IDLE;
  - any CR in any state;
  - completion of a G_ADR, W_ADR or R_END token;
  - any `cmd_err`.
  - Several of these in the same character produce a single pulse.
- **Busy flags:** `*_running` deasserting in a state that does not watch it has no effect.

## Timing
- **Input stage:** `rout`/`rout_en` are registered into `pdata`/`data_en`. Character accepted at cycle N is decoded at N+1; state, accumulator and output registers update at the N+2 edge. All pulses are therefore high for exactly cycle N+2.
- **Data outputs:** `adr_out`/`dat_out` are valid in the same cycle as their strobe and hold until the next completed token of the same kind.
- **Busy-flag exits:** state exits on `~*_running` take effect on the next edge, with no output pulse.
- **Character spacing:** back-to-back `rout_en` on consecutive cycles must be handled; the pipeline has no stall.
- **Reset:**
  - All outputs are 0.
  - `adr_out` and `dat_out` are 0.
  - State is IDLE; `acc` and `ndig` are 0.
  - Reset assertion mid-command aborts it with no pulses.

## Structure
- **Package `monitor_pkg`:**
  - State enum `mon_state_t` (IDLE, G_ADR, G_RUN, W_ADR, W_DAT, R_STA, R_END, R_DUMP, T_RUN, S_RUN).
  - ASCII constants: `CH_SP`, `CH_CR`, and the command letters.
  - Function `hex_nibble` returning `{valid, nibble[3:0]}`.
- **Sub-module `hex_token_acc`:** parameter `ACC_W`; inputs digit strobe, nibble, clear and limit; outputs `acc`, `ndig` and overflow. The FSM stays in the top module.

## Test plan
- **Write with defaults:** `w 1F 0a B3 q` → `write_address_set` with `adr_out`=0x1F; two `write_data_en` pulses with `dat_out`=0x0A then 0xB3; `quit_cmd`; state IDLE.
- **Wide go:** ADR_W=16, `g 12` then CR → `cpu_start` with `adr_out`=0x0012 and `crlf_in` in the same cycle. Then `q` → `quit_cmd`.
- **Overflow:** default widths, `w 123` → `cmd_err` on the third digit, `crlf_in`, IDLE, no `write_address_set`.
- **Read and dump abort:** `r 10 20 ` → `read_start_set`(0x10), `read_end_set`(0x20), R_DUMP while `dump_running`=1. `q` → `read_stop` and `quit_cmd`. Repeat with `dump_running` dropping instead → IDLE with no `read_stop`.
- **Back-to-back characters and multiple separators:** `rout_en` on consecutive cycles with `w  5  6 q` → `adr_out`=0x05, one write of 0x06. Each pulse lands exactly 2 cycles after its terminating character.
- **Reset mid-command:** assert `rst_n`=0 after `w 4` → all outputs 0, IDLE. The next `5` character is ignored.

Source files
------------

// File: rtl/monitor_cmd_ctrl_pkg.sv
// Shared types, ASCII constants and the hex decode helper for the UART monitor command controller.
package monitor_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      G_ADR  = 4'd1,
      G_RUN  = 4'd2,
      W_ADR  = 4'd3,
      W_DAT  = 4'd4,
      R_STA  = 4'd5,
      R_END  = 4'd6,
      R_DUMP = 4'd7,
      T_RUN  = 4'd8,
      S_RUN  = 4'd9
   } mon_state_t;

   localparam logic [7:0] CH_SP = 8'h20;
   localparam logic [7:0] CH_CR = 8'h0d;
   localparam logic [7:0] CH_G  = 8'h67;
   localparam logic [7:0] CH_W  = 8'h77;
   localparam logic [7:0] CH_R  = 8'h72;
   localparam logic [7:0] CH_T  = 8'h74;
   localparam logic [7:0] CH_S  = 8'h73;
   localparam logic [7:0] CH_Q  = 8'h71;

   // One-cycle strobes towards the monitor datapath
   typedef struct packed {
      logic cpu_start;
      logic write_address_set;
      logic write_data_en;
      logic read_start_set;
      logic read_end_set;
      logic read_stop;
      logic start_trush;
      logic start_step;
      logic quit_cmd;
      logic crlf_in;
      logic cmd_err;
   } mon_pulse_t;

   // Returns {valid, nibble}; accepts 0-9, a-f and A-F
   function automatic logic [4:0] hex_nibble(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
      else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
      else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
      return r;
   endfunction

endpackage

// File: rtl/monitor_cmd_ctrl_if.sv
// Character input, busy flags and command strobes between the UART side and the command controller.
interface monitor_cmd_ctrl_if #(
   parameter int unsigned ADR_W = 8,
   parameter int unsigned DAT_W = 8
);
   logic [7:0]       rout;
   logic             rout_en;
   logic             dump_running;
   logic             trush_running;
   logic             cpu_running;
   logic [ADR_W-1:0] adr_out;
   logic [DAT_W-1:0] dat_out;
   logic             cpu_start;
   logic             write_address_set;
   logic             write_data_en;
   logic             read_start_set;
   logic             read_end_set;
   logic             read_stop;
   logic             start_trush;
   logic             start_step;
   logic             quit_cmd;
   logic             crlf_in;
   logic             cmd_err;

   modport master (
      output rout, rout_en, dump_running, trush_running, cpu_running,
      input  adr_out, dat_out, cpu_start, write_address_set, write_data_en,
             read_start_set, read_end_set, read_stop, start_trush, start_step,
             quit_cmd, crlf_in, cmd_err
   );

   modport slave (
      input  rout, rout_en, dump_running, trush_running, cpu_running,
      output adr_out, dat_out, cpu_start, write_address_set, write_data_en,
             read_start_set, read_end_set, read_stop, start_trush, start_step,
             quit_cmd, crlf_in, cmd_err
   );
endinterface

// File: rtl/monitor_cmd_ctrl_hex_token_acc.sv
// Hex token accumulator: shifts in nibbles up to a per-field digit limit and flags the digit that would exceed it.
module hex_token_acc #(
   parameter int unsigned ACC_W = 8,
   localparam int unsigned NDIG_W = $clog2(ACC_W / 4 + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dig_en,
   input  logic [3:0]        nibble,
   input  logic              clr,
   input  logic [NDIG_W-1:0] limit,
   output logic [ACC_W-1:0]  acc,
   output logic [NDIG_W-1:0] ndig,
   output logic              ovf_c
);

   assign ovf_c = dig_en && (ndig >= limit);

   // Clear wins over a digit so a rejected digit never lands in the next token
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         ndig <= '0;
      end else if (clr) begin
         acc  <= '0;
         ndig <= '0;
      end else if (dig_en && !ovf_c) begin
         acc  <= ACC_W'({acc, nibble});
         ndig <= ndig + NDIG_W'(1);
      end
   end

endmodule

// File: rtl/monitor_cmd_ctrl.sv
// UART monitor command parser: registers each received character, then decodes it into
// state changes and one-cycle strobes on the following edge.
module monitor_cmd_ctrl
   import monitor_pkg::*;
#(
   parameter int unsigned ADR_W = 8,
   parameter int unsigned DAT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   monitor_cmd_ctrl_if.slave bus
);

   localparam int unsigned ACC_W  = (ADR_W > DAT_W) ? ADR_W : DAT_W;
   localparam int unsigned NDIG_W = $clog2(ACC_W / 4 + 1);
   localparam logic [NDIG_W-1:0] ADR_DIGS = NDIG_W'(ADR_W / 4);
   localparam logic [NDIG_W-1:0] DAT_DIGS = NDIG_W'(DAT_W / 4);

   localparam logic [3:0] ST_IDLE   = 4'(IDLE);
   localparam logic [3:0] ST_G_ADR  = 4'(G_ADR);
   localparam logic [3:0] ST_G_RUN  = 4'(G_RUN);
   localparam logic [3:0] ST_W_ADR  = 4'(W_ADR);
   localparam logic [3:0] ST_W_DAT  = 4'(W_DAT);
   localparam logic [3:0] ST_R_STA  = 4'(R_STA);
   localparam logic [3:0] ST_R_END  = 4'(R_END);
   localparam logic [3:0] ST_R_DUMP = 4'(R_DUMP);
   localparam logic [3:0] ST_T_RUN  = 4'(T_RUN);
   localparam logic [3:0] ST_S_RUN  = 4'(S_RUN);

   logic [7:0]       pdata;
   logic             data_en;
   logic [3:0]       state_q, state_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [DAT_W-1:0] dat_q, dat_d;
   mon_pulse_t       pulse_q, pulse_d;

   logic [4:0]        hex_c;
   logic              is_dig, is_sep, is_cr, is_q;
   logic              collecting;
   logic              acc_dig_en, acc_clr, acc_ovf;
   logic [NDIG_W-1:0] acc_limit;
   logic [ACC_W-1:0]  acc;
   logic [NDIG_W-1:0] ndig;

   // Input stage: one character per cycle, no stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pdata   <= '0;
         data_en <= 1'b0;
      end else begin
         pdata   <= bus.rout;
         data_en <= bus.rout_en;
      end
   end

   assign hex_c  = hex_nibble(pdata);
   assign is_dig = data_en && hex_c[4];
   assign is_cr  = data_en && (pdata == CH_CR);
   assign is_sep = data_en && ((pdata == CH_SP) || (pdata == CH_CR));
   assign is_q   = data_en && (pdata == CH_Q);

   assign collecting = state_q inside {ST_G_ADR, ST_W_ADR, ST_W_DAT, ST_R_STA, ST_R_END};
   assign acc_limit  = (state_q == ST_W_DAT) ? DAT_DIGS : ADR_DIGS;
   assign acc_dig_en = collecting && is_dig;

   hex_token_acc #(.ACC_W(ACC_W)) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .dig_en (acc_dig_en),
      .nibble (hex_c[3:0]),
      .clr    (acc_clr),
      .limit  (acc_limit),
      .acc    (acc),
      .ndig   (ndig),
      .ovf_c  (acc_ovf)
   );

   // Next state, token completion and strobes for the decoded character
   always_comb begin
      state_d         = state_q;
      adr_d           = adr_q;
      dat_d           = dat_q;
      pulse_d         = '0;
      acc_clr         = 1'b0;
      pulse_d.crlf_in = is_cr;

      if (is_q) begin
         state_d          = ST_IDLE;
         acc_clr          = 1'b1;
         pulse_d.quit_cmd = 1'b1;
         if (state_q == ST_R_DUMP) pulse_d.read_stop = 1'b1;
         if (state_q == ST_IDLE)   pulse_d.crlf_in   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (data_en) begin
                  case (pdata)
                     CH_G: state_d = ST_G_ADR;
                     CH_W: state_d = ST_W_ADR;
                     CH_R: state_d = ST_R_STA;
                     CH_T: begin
                        state_d             = ST_T_RUN;
                        pulse_d.start_trush = 1'b1;
                        pulse_d.crlf_in     = 1'b1;
                     end
                     CH_S: begin
                        state_d            = ST_S_RUN;
                        pulse_d.start_step = 1'b1;
                        pulse_d.crlf_in    = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_G_ADR, ST_W_ADR, ST_W_DAT, ST_R_STA, ST_R_END: begin
               if (acc_ovf || (data_en && !hex_c[4] && !is_sep)) begin
                  state_d         = ST_IDLE;
                  acc_clr         = 1'b1;
                  pulse_d.cmd_err = 1'b1;
                  pulse_d.crlf_in = 1'b1;
               end else if (is_sep && (ndig != '0)) begin
                  acc_clr = 1'b1;
                  case (state_q)
                     ST_G_ADR: begin
                        adr_d             = ADR_W'(acc);
                        pulse_d.cpu_start = 1'b1;
                        pulse_d.crlf_in   = 1'b1;
                        state_d           = ST_G_RUN;
                     end
                     ST_W_ADR: begin
                        adr_d                     = ADR_W'(acc);
                        pulse_d.write_address_set = 1'b1;
                        pulse_d.crlf_in           = 1'b1;
                        state_d                   = ST_W_DAT;
                     end
                     ST_W_DAT: begin
                        dat_d                 = DAT_W'(acc);
                        pulse_d.write_data_en = 1'b1;
                     end
                     ST_R_STA: begin
                        adr_d                  = ADR_W'(acc);
                        pulse_d.read_start_set = 1'b1;
                        state_d                = ST_R_END;
                     end
                     ST_R_END: begin
                        adr_d                = ADR_W'(acc);
                        pulse_d.read_end_set = 1'b1;
                        pulse_d.crlf_in      = 1'b1;
                        state_d              = ST_R_DUMP;
                     end
                     default: ;
                  endcase
               end
            end
            ST_G_RUN:  ;
            ST_R_DUMP: if (!bus.dump_running)  state_d = ST_IDLE;
            ST_T_RUN:  if (!bus.trush_running) state_d = ST_IDLE;
            ST_S_RUN:  if (!bus.cpu_running)   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         pulse_q <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         pulse_q <= pulse_d;
      end
   end

   assign bus.adr_out           = adr_q;
   assign bus.dat_out           = dat_q;
   assign bus.cpu_start         = pulse_q.cpu_start;
   assign bus.write_address_set = pulse_q.write_address_set;
   assign bus.write_data_en     = pulse_q.write_data_en;
   assign bus.read_start_set    = pulse_q.read_start_set;
   assign bus.read_end_set      = pulse_q.read_end_set;
   assign bus.read_stop         = pulse_q.read_stop;
   assign bus.start_trush       = pulse_q.start_trush;
   assign bus.start_step        = pulse_q.start_step;
   assign bus.quit_cmd          = pulse_q.quit_cmd;
   assign bus.crlf_in           = pulse_q.crlf_in;
   assign bus.cmd_err           = pulse_q.cmd_err;

endmodule

// File: tb/tb_monitor_cmd_ctrl.sv
// Bench for monitor_cmd_ctrl: an 8/8 and a 16/8 instance share one character stream and are
// compared every cycle against a character-level reference model.
module tb_monitor_cmd_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic dr, tr, cr;

   monitor_cmd_ctrl_if #(.ADR_W(8),  .DAT_W(8)) b8();
   monitor_cmd_ctrl_if #(.ADR_W(16), .DAT_W(8)) b16();

   monitor_cmd_ctrl #(.ADR_W(8),  .DAT_W(8)) u_d8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   monitor_cmd_ctrl #(.ADR_W(16), .DAT_W(8)) u_d16 (.clk(clk), .rst_n(rst_n), .bus(b16));

   // Bit order: cpu, wadr, wdat, rsta, rend, rstop, trush, step, quit, crlf, err
   logic [10:0] p8, p16;
   assign p8  = {b8.cpu_start, b8.write_address_set, b8.write_data_en, b8.read_start_set,
                 b8.read_end_set, b8.read_stop, b8.start_trush, b8.start_step,
                 b8.quit_cmd, b8.crlf_in, b8.cmd_err};
   assign p16 = {b16.cpu_start, b16.write_address_set, b16.write_data_en, b16.read_start_set,
                 b16.read_end_set, b16.read_stop, b16.start_trush, b16.start_step,
                 b16.quit_cmd, b16.crlf_in, b16.cmd_err};

   typedef enum int {M_IDLE, M_GA, M_GR, M_WA, M_WD, M_RS, M_RE, M_RD, M_TR, M_SR} mode_t;

   mode_t       mode    [2];
   int unsigned val     [2];
   int unsigned ndig    [2];
   int unsigned exp_adr [2];
   int unsigned exp_dat [2];
   logic [10:0] exp_p   [2];
   int unsigned adr_w   [2];

   logic        pend_en;
   logic [7:0]  pend_ch;
   int          n_chk, n_pass;
   int          cnt_wadr8, cnt_err8, cnt_rstop8;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
   endtask

   function automatic int nib_of(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      if (c >= "A" && c <= "F") return int'(c) - 55;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mode[i] = M_IDLE; val[i] = 0; ndig[i] = 0;
         exp_adr[i] = 0; exp_dat[i] = 0; exp_p[i] = '0;
      end
   endtask

   // Effect of one decoded character (plus current busy flags) on instance i
   task automatic model_step(input int i, input logic en, input logic [7:0] ch);
      mode_t       m0;
      int          nb;
      int unsigned lim;
      bit          quit;
      logic [10:0] p;
      m0   = mode[i];
      p    = '0;
      quit = en && (ch == "q");
      if (en) begin
         nb = nib_of(ch);
         if (ch == 8'h0d) p[1] = 1'b1;
         if (quit) begin
            if (m0 == M_IDLE) p[1] = 1'b1;
            if (m0 == M_RD)   p[5] = 1'b1;
            p[2] = 1'b1; mode[i] = M_IDLE; val[i] = 0; ndig[i] = 0;
         end else if (m0 inside {M_GA, M_WA, M_WD, M_RS, M_RE}) begin
            lim = (m0 == M_WD) ? 2 : adr_w[i] / 4;
            if (nb >= 0 && ndig[i] < lim) begin
               val[i] = val[i] * 16 + nb; ndig[i]++;
            end else if (nb < 0 && (ch == 8'h20 || ch == 8'h0d)) begin
               if (ndig[i] > 0) begin
                  case (m0)
                     M_GA: begin exp_adr[i] = val[i]; p[10] = 1'b1; p[1] = 1'b1; mode[i] = M_GR; end
                     M_WA: begin exp_adr[i] = val[i]; p[9] = 1'b1;  p[1] = 1'b1; mode[i] = M_WD; end
                     M_WD: begin exp_dat[i] = val[i]; p[8] = 1'b1; end
                     M_RS: begin exp_adr[i] = val[i]; p[7] = 1'b1;  mode[i] = M_RE; end
                     M_RE: begin exp_adr[i] = val[i]; p[6] = 1'b1;  p[1] = 1'b1; mode[i] = M_RD; end
                     default: ;
                  endcase
                  val[i] = 0; ndig[i] = 0;
               end
            end else begin
               p[0] = 1'b1; p[1] = 1'b1; mode[i] = M_IDLE; val[i] = 0; ndig[i] = 0;
            end
         end else if (m0 == M_IDLE) begin
            case (ch)
               "g": mode[i] = M_GA;
               "w": mode[i] = M_WA;
               "r": mode[i] = M_RS;
               "t": begin mode[i] = M_TR; p[4] = 1'b1; p[1] = 1'b1; end
               "s": begin mode[i] = M_SR; p[3] = 1'b1; p[1] = 1'b1; end
               default: ;
            endcase
         end
      end
      if (!quit && ((m0 == M_RD && !dr) || (m0 == M_TR && !tr) || (m0 == M_SR && !cr)))
         mode[i] = M_IDLE;
      exp_p[i] = p;
   endtask

   // One cycle: check outputs, drive the next character, advance the model
   task automatic tick(input logic en, input logic [7:0] ch);
      @(negedge clk);
      check("d8.pulse",  32'(p8),           32'(exp_p[0]));
      check("d8.adr",    32'(b8.adr_out),   exp_adr[0]);
      check("d8.dat",    32'(b8.dat_out),   exp_dat[0]);
      check("d16.pulse", 32'(p16),          32'(exp_p[1]));
      check("d16.adr",   32'(b16.adr_out),  exp_adr[1]);
      check("d16.dat",   32'(b16.dat_out),  exp_dat[1]);
      if (p8[9]) cnt_wadr8++;
      if (p8[0]) cnt_err8++;
      if (p8[5]) cnt_rstop8++;
      b8.rout  = ch;  b8.rout_en  = en;
      b16.rout = ch;  b16.rout_en = en;
      b8.dump_running  = dr; b8.trush_running  = tr; b8.cpu_running  = cr;
      b16.dump_running = dr; b16.trush_running = tr; b16.cpu_running = cr;
      if (!rst_n) model_reset();
      else begin
         model_step(0, pend_en, pend_ch);
         model_step(1, pend_en, pend_ch);
      end
      pend_en = en;
      pend_ch = ch;
   endtask

   task automatic send(input string s, input int gap);
      for (int k = 0; k < s.len(); k++) begin
         tick(1'b1, s[k]);
         repeat (gap) tick(1'b0, 8'h00);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00);
   endtask

   task automatic clear_counts();
      cnt_wadr8 = 0; cnt_err8 = 0; cnt_rstop8 = 0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      model_reset();
      idle(2);
      rst_n = 1'b1;
   endtask

   function automatic logic [7:0] rand_char();
      string hx, cm;
      int    r;
      hx = "0123456789abcdefABCDEF";
      cm = "gwrts";
      r  = int'($urandom_range(0, 19));
      if (r <= 5)  return hx[$urandom_range(0, 21)];
      if (r <= 8)  return 8'h20;
      if (r == 9)  return 8'h0d;
      if (r <= 14) return cm[$urandom_range(0, 4)];
      if (r == 15) return "q";
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      n_chk = 0; n_pass = 0;
      adr_w[0] = 8; adr_w[1] = 16;
      dr = 1'b1; tr = 1'b1; cr = 1'b1;
      pend_en = 1'b0; pend_ch = 8'h00;
      clear_counts();
      model_reset();
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Write with defaults
      clear_counts();
      send("w 1F 0a B3 q", 1);
      idle(3);
      check("wr.adr", 32'(b8.adr_out), 32'h1F);
      check("wr.dat", 32'(b8.dat_out), 32'hB3);
      check("wr.nadr", 32'(cnt_wadr8), 32'd1);

      // Wide go on the 16-bit instance
      send("g 12", 0);
      tick(1'b1, 8'h0d);
      idle(3);
      check("go.adr16", 32'(b16.adr_out), 32'h0012);
      send("q", 0);
      idle(3);

      // Address overflow on the 8-bit instance
      clear_counts();
      send("w 123", 0);
      idle(3);
      check("ovf.err", 32'(cnt_err8), 32'd1);
      check("ovf.nadr", 32'(cnt_wadr8), 32'd0);
      send(" q", 0);
      idle(3);

      // Read then abort with q, then read ended by dump_running
      clear_counts();
      send("r 10 20 ", 1);
      idle(5);
      send("q", 0);
      idle(3);
      check("rd.stop", 32'(cnt_rstop8), 32'd1);
      clear_counts();
      send("r 10 20 ", 1);
      idle(3);
      dr = 1'b0;
      idle(3);
      dr = 1'b1;
      send("q", 0);
      idle(3);
      check("rd.nostop", 32'(cnt_rstop8), 32'd0);

      // Back-to-back characters with separator runs
      send("w  5  6 q", 0);
      idle(3);
      check("b2b.adr", 32'(b8.adr_out), 32'h05);
      check("b2b.dat", 32'(b8.dat_out), 32'h06);

      // Reset mid-command drops the partial token
      send("w 4", 0);
      pulse_reset();
      check("rst.adr", 32'(b8.adr_out), 32'h0);
      send("5 ", 0);
      send("w 7 q", 0);
      idle(3);
      check("rst.next", 32'(b8.adr_out), 32'h07);

      // Randomised character stream with busy-flag activity
      for (int c = 0; c < 5000; c++) begin
         dr = ($urandom_range(0, 19) != 0);
         tr = ($urandom_range(0, 19) != 0);
         cr = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 1499) == 0) pulse_reset();
         tick($urandom_range(0, 2) != 0, rand_char());
      end
      dr = 1'b1; tr = 1'b1; cr = 1'b1;
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
